uart_frame_loader: RTL and testbench



---
 rtl/uart_frame_loader.sv | 139 +++++++++++++
 tb/tb_uart_frame_loader.sv | 231 +++++++++++++++++++++++
 2 files changed

// File: rtl/uart_frame_loader.sv
// Framed UART upload loader: parses a 4-byte little-endian word-count header,
// packs the payload bytes little-endian into words and writes them to RAM,
// and exposes a pollable status word on the data bus.
module uart_frame_loader #(
  parameter int unsigned WIDTH      = 32,
  parameter int unsigned BASEADDR   = 0,
  parameter int unsigned MAXWORDS   = 65535,
  parameter int unsigned TIMEOUT    = 100000,
  parameter logic [31:0] STATUSADDR = 32'h0006_4834
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             bytevalid,
  input  logic [7:0]       bytedata,
  output logic             wram,
  output logic [WIDTH-1:0] ramaddress,
  output logic [WIDTH-1:0] wramdata,
  input  logic [31:0]      busaddr,
  output logic [31:0]      busdata,
  output logic             done,
  output logic             error
);

  localparam int unsigned CW = 17;
  localparam int unsigned TW = $clog2(TIMEOUT + 1);

  typedef enum logic [2:0] {
    S_IDLE,
    S_HEADER,
    S_DATA,
    S_DONE,
    S_ERR
  } state_t;

  state_t        state;
  state_t        state_next;
  logic [31:0]   shreg;
  logic [1:0]    bcnt;
  logic [CW-1:0] length;
  logic [CW-1:0] wordswritten;
  logic [TW-1:0] timer;

  logic [31:0]   word_c;
  logic [CW-1:0] ww_inc_c;
  logic          last_byte_c;
  logic          timed_out_c;
  logic          busy_c;

  // Byte being accepted completes the shift register; a byte always beats the timer.
  assign word_c      = {bytedata, shreg[31:8]};
  assign ww_inc_c    = wordswritten + CW'(1);
  assign last_byte_c = (bcnt == 2'd3);
  assign timed_out_c = !bytevalid && (timer == TW'(TIMEOUT - 1));
  assign busy_c      = (state == S_HEADER) || (state == S_DATA);

  // State register
  always_ff @(posedge clk or posedge rst) begin
    if (rst) state <= S_IDLE;
    else     state <= state_next;
  end

  // Next-state decode
  always_comb begin
    state_next = state;
    case (state)
      S_IDLE, S_DONE, S_ERR: begin
        if (bytevalid) state_next = S_HEADER;
      end
      S_HEADER: begin
        if (bytevalid && last_byte_c) begin
          if (word_c == 32'd0)                state_next = S_DONE;
          else if (word_c > 32'(MAXWORDS))    state_next = S_ERR;
          else                                state_next = S_DATA;
        end else if (timed_out_c) begin
          state_next = S_ERR;
        end
      end
      S_DATA: begin
        if (bytevalid && last_byte_c && (ww_inc_c == length)) state_next = S_DONE;
        else if (timed_out_c)                                state_next = S_ERR;
      end
      default: state_next = S_IDLE;
    endcase
  end

  // Datapath: byte packing, counters, idle timer and registered RAM/flag outputs
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      shreg        <= '0;
      bcnt         <= '0;
      length       <= '0;
      wordswritten <= '0;
      timer        <= '0;
      wram         <= 1'b0;
      ramaddress   <= '0;
      wramdata     <= '0;
      done         <= 1'b0;
      error        <= 1'b0;
    end else begin
      wram  <= 1'b0;
      done  <= (state_next == S_DONE);
      error <= (state_next == S_ERR);

      if (busy_c && !bytevalid) timer <= timer + TW'(1);
      else                      timer <= '0;

      if (bytevalid) begin
        shreg <= word_c;
        case (state)
          S_IDLE, S_DONE, S_ERR: begin
            bcnt         <= 2'd1;
            wordswritten <= '0;
          end
          S_HEADER: begin
            bcnt <= bcnt + 2'd1;
            if (last_byte_c) length <= CW'(word_c);
          end
          S_DATA: begin
            bcnt <= bcnt + 2'd1;
            if (last_byte_c) begin
              wram       <= 1'b1;
              ramaddress <= WIDTH'(BASEADDR) + WIDTH'(wordswritten);
              wramdata   <= WIDTH'(word_c);
              if (wordswritten != CW'(MAXWORDS)) wordswritten <= ww_inc_c;
            end
          end
          default: bcnt <= '0;
        endcase
      end
    end
  end

  // Status word decode
  always_comb begin
    busdata = '0;
    if (busaddr == STATUSADDR) busdata = {done, error, busy_c, 13'b0, wordswritten[15:0]};
  end

endmodule

// File: tb/tb_uart_frame_loader.sv
// Bench for uart_frame_loader: table of frames plus hand-written timeout and reset sequences.
module tb_uart_frame_loader;

  localparam int unsigned TO   = 20;
  localparam int unsigned BASE = 32'h40;
  localparam logic [31:0] SA   = 32'h0006_4834;

  logic        clk = 1'b0;
  logic        rst;
  logic        bytevalid;
  logic [7:0]  bytedata;
  logic        wram;
  logic [31:0] ramaddress;
  logic [31:0] wramdata;
  logic [31:0] busaddr;
  logic [31:0] busdata;
  logic        done;
  logic        error;

  uart_frame_loader #(
    .WIDTH(32), .BASEADDR(BASE), .MAXWORDS(65535), .TIMEOUT(TO), .STATUSADDR(SA)
  ) dut (
    .clk(clk), .rst(rst), .bytevalid(bytevalid), .bytedata(bytedata),
    .wram(wram), .ramaddress(ramaddress), .wramdata(wramdata),
    .busaddr(busaddr), .busdata(busdata), .done(done), .error(error)
  );

  always #5 clk = ~clk;

  typedef struct {
    logic [31:0] addr;
    logic [31:0] data;
  } wr_t;

  typedef struct {
    logic [31:0] len;
    int          n;
    logic [7:0]  base;
    logic [7:0]  step;
    bit          immediate;
    logic        exp_done;
    logic        exp_err;
    logic [31:0] status;
    int          exp_writes;
  } vec_t;

  wr_t         sbq[$];
  wr_t         exp_w;
  logic [31:0] last_addr;
  logic [31:0] last_data;
  int          checks  = 0;
  int          errors  = 0;
  int          nwrites = 0;
  int          w0;

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s actual=%h required=%h", name, act, exp);
    end
  endtask

  // Caller is at a negedge; byte is sampled on the next posedge and we return at the following negedge.
  task automatic send_byte(input logic [7:0] b);
    bytevalid = 1'b1;
    bytedata  = b;
    @(negedge clk);
    bytevalid = 1'b0;
  endtask

  task automatic send_frame(input logic [31:0] len, input int n, input logic [7:0] base,
                            input logic [7:0] step, input bit gaps);
    logic [31:0] word;
    logic [7:0]  b;
    wr_t         w;
    word = '0;
    for (int i = 0; i < 4; i++) begin
      send_byte(len[8*i +: 8]);
      if (gaps) repeat ($urandom_range(0, 2)) @(negedge clk);
    end
    for (int i = 0; i < n; i++) begin
      b    = base + 8'(i) * step;
      word = {b, word[31:8]};
      if (i % 4 == 3) begin
        w.addr = BASE + 32'(i / 4);
        w.data = word;
        sbq.push_back(w);
        last_addr = w.addr;
        last_data = w.data;
      end
      send_byte(b);
      if (gaps && i != n - 1) repeat ($urandom_range(0, 2)) @(negedge clk);
    end
  endtask

  // Scoreboard consumer: every RAM write must match the next expected word
  always @(negedge clk) begin
    if (wram) begin
      nwrites++;
      if (sbq.size() == 0) begin
        checks++;
        errors++;
        $display("FAIL unexpected_write actual addr=%h data=%h required none", ramaddress, wramdata);
      end else begin
        exp_w = sbq.pop_front();
        check("wr_addr", ramaddress, exp_w.addr);
        check("wr_data", wramdata, exp_w.data);
      end
    end
  end

  initial begin
    #2_000_000;
    $display("FAIL watchdog actual=timeout required=finish");
    $fatal(1, "watchdog");
  end

  vec_t tbl[6];

  initial begin
    tbl[0] = '{32'd2,          8,  8'h11, 8'h11, 1'b1, 1'b1, 1'b0, 32'h8000_0002, 2};
    tbl[1] = '{32'd0,          0,  8'h00, 8'h00, 1'b1, 1'b1, 1'b0, 32'h8000_0000, 0};
    tbl[2] = '{32'h0001_0000,  0,  8'h00, 8'h00, 1'b1, 1'b0, 1'b1, 32'h4000_0000, 0};
    tbl[3] = '{32'h0000_FFFF,  0,  8'h00, 8'h00, 1'b0, 1'b0, 1'b1, 32'h4000_0000, 0};
    tbl[4] = '{32'd3,          12, 8'hA0, 8'h07, 1'b1, 1'b1, 1'b0, 32'h8000_0003, 3};
    tbl[5] = '{32'd1,          4,  8'hFF, 8'hFF, 1'b1, 1'b1, 1'b0, 32'h8000_0001, 1};

    rst       = 1'b1;
    bytevalid = 1'b0;
    bytedata  = 8'h00;
    busaddr   = SA;
    repeat (3) @(negedge clk);
    check("rst_wram", 32'(wram), 32'd0);
    check("rst_addr", ramaddress, 32'd0);
    check("rst_data", wramdata, 32'd0);
    check("rst_done", 32'(done), 32'd0);
    check("rst_error", 32'(error), 32'd0);
    check("rst_status", busdata, 32'd0);
    rst = 1'b0;
    @(negedge clk);

    for (int c = 0; c < 6; c++) begin
      w0 = nwrites;
      busaddr = SA;
      send_frame(tbl[c].len, tbl[c].n, tbl[c].base, tbl[c].step, 1'b1);
      if (tbl[c].immediate) begin
        check($sformatf("c%0d_done_now", c), 32'(done), 32'(tbl[c].exp_done));
        check($sformatf("c%0d_err_now", c), 32'(error), 32'(tbl[c].exp_err));
      end else begin
        #1;
        check($sformatf("c%0d_busy", c), 32'(busdata[29]), 32'd1);
        check($sformatf("c%0d_early_err", c), 32'(error), 32'd0);
        for (int k = 0; k < int'(TO) + 5 && !(done || error); k++) @(negedge clk);
      end
      #1;
      check($sformatf("c%0d_done", c), 32'(done), 32'(tbl[c].exp_done));
      check($sformatf("c%0d_error", c), 32'(error), 32'(tbl[c].exp_err));
      check($sformatf("c%0d_status", c), busdata, tbl[c].status);
      check($sformatf("c%0d_writes", c), 32'(nwrites - w0), 32'(tbl[c].exp_writes));
      check($sformatf("c%0d_sbq", c), 32'(sbq.size()), 32'd0);
      busaddr = SA + 32'd4;
      #1;
      check($sformatf("c%0d_other_addr", c), busdata, 32'd0);
      busaddr = SA;
      @(negedge clk);
    end

    check("hold_addr", ramaddress, last_addr);
    check("hold_data", wramdata, last_data);

    // Silence after two payload bytes: error exactly TO cycles after the last byte
    w0 = nwrites;
    send_byte(8'h01);
    check("newframe_clears_done", 32'(done), 32'd0);
    send_byte(8'h00); send_byte(8'h00); send_byte(8'h00);
    send_byte(8'hAA); send_byte(8'hBB);
    repeat (TO - 1) @(negedge clk);
    check("to_before", 32'(error), 32'd0);
    @(negedge clk);
    check("to_at", 32'(error), 32'd1);
    #1;
    check("to_status", busdata, 32'h4000_0000);
    check("to_writes", 32'(nwrites - w0), 32'd0);

    // Byte on the exact timeout cycle wins and the frame completes
    @(negedge clk);
    send_byte(8'h01); send_byte(8'h00); send_byte(8'h00); send_byte(8'h00);
    send_byte(8'hC1); send_byte(8'hC2); send_byte(8'hC3);
    repeat (TO - 1) @(negedge clk);
    check("edge_pre_err", 32'(error), 32'd0);
    sbq.push_back('{BASE, 32'hC4C3_C2C1});
    send_byte(8'hC4);
    check("edge_err", 32'(error), 32'd0);
    check("edge_done", 32'(done), 32'd1);
    #1;
    check("edge_sbq", 32'(sbq.size()), 32'd0);
    check("edge_status", busdata, 32'h8000_0001);

    // Reset between payload bytes 2 and 3, then a fresh frame from BASE
    @(negedge clk);
    send_byte(8'h02); send_byte(8'h00); send_byte(8'h00); send_byte(8'h00);
    send_byte(8'h5A); send_byte(8'h5B);
    rst = 1'b1;
    #1;
    check("mid_rst_wram", 32'(wram), 32'd0);
    check("mid_rst_addr", ramaddress, 32'd0);
    check("mid_rst_data", wramdata, 32'd0);
    check("mid_rst_done", 32'(done), 32'd0);
    check("mid_rst_error", 32'(error), 32'd0);
    check("mid_rst_status", busdata, 32'd0);
    @(negedge clk);
    rst = 1'b0;
    @(negedge clk);
    w0 = nwrites;
    send_frame(32'd1, 4, 8'h31, 8'h02, 1'b0);
    #1;
    check("post_rst_done", 32'(done), 32'd1);
    check("post_rst_writes", 32'(nwrites - w0), 32'd1);
    check("post_rst_sbq", 32'(sbq.size()), 32'd0);
    check("post_rst_status", busdata, 32'h8000_0001);
    busaddr = SA ^ 32'h1;
    #1;
    check("post_rst_other_addr", busdata, 32'd0);

    repeat (2) @(negedge clk);
    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
